// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit positions, frame width and FSM state encoding.
// The console-side receiver uses the same package.
package nes_pkg;

  localparam int NES_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_t;

endpackage

// File: rtl/nes_sync_edge.sv
// Pin synchroniser (SYNC_STAGES flops) followed by one edge-detect flop.
// o_rise/o_fall are single-cycle pulses aligned with the synchronised level change.
module nes_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/nes_controller_responder.sv
// Emulates the 4021 shift register inside a standard NES pad (device side of the serial link).
// Optional turbo on A/B is enabled by defining NES_TURBO_EN.
module nes_controller_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_nes_latch,
  input  logic                i_nes_clk,
  input  logic [NES_BITS-1:0] i_buttons,
  input  logic                i_turbo_a,
  input  logic                i_turbo_b,
  output logic                o_nes_data,
  output logic                o_busy,
  output logic [3:0]          o_bits_sent,
  output logic                o_frame_strobe
);

  logic                w_latch_lvl, w_latch_rise, w_latch_fall;
  logic                w_clk_lvl, w_clk_rise, w_clk_fall;
  logic [NES_BITS-1:0] w_buttons_eff;

  nes_state_t          r_state, w_state_next;
  logic [NES_BITS-1:0] r_shift, w_shift_next;
  logic [3:0]          r_bits, w_bits_next;
  logic                r_nes_data, w_data_next;
  logic                r_frame_strobe, w_strobe_next;

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (i_nes_latch),
    .o_level (w_latch_lvl),
    .o_rise  (w_latch_rise),
    .o_fall  (w_latch_fall)
  );

  nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (i_nes_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  logic w_unused_edges;
  assign w_unused_edges = &{1'b0, w_latch_rise, w_clk_lvl, w_clk_fall};

`ifdef NES_TURBO_EN
  localparam int TC_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [TC_W-1:0] r_turbo_cnt;
  logic            r_turbo_phase;

  // Phase flips once every TURBO_PERIOD latch frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_turbo_cnt   <= '0;
      r_turbo_phase <= 1'b0;
    end else if (r_frame_strobe) begin
      if (r_turbo_cnt == TC_W'(TURBO_PERIOD - 1)) begin
        r_turbo_cnt   <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_buttons_eff        = i_buttons;
    w_buttons_eff[BTN_A] = i_buttons[BTN_A] & ~(i_turbo_a & r_turbo_phase);
    w_buttons_eff[BTN_B] = i_buttons[BTN_B] & ~(i_turbo_b & r_turbo_phase);
  end
`else
  logic w_unused_turbo;
  assign w_unused_turbo = &{1'b0, i_turbo_a, i_turbo_b, TURBO_PERIOD[0]};
  assign w_buttons_eff  = i_buttons;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_shift        <= '1;
      r_bits         <= '0;
      r_nes_data     <= 1'b1;
      r_frame_strobe <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_shift        <= w_shift_next;
      r_bits         <= w_bits_next;
      r_nes_data     <= w_data_next;
      r_frame_strobe <= w_strobe_next;
    end
  end

  // Latch level has priority over everything, so a coincident clock edge never shifts.
  always_comb begin
    w_state_next = r_state;
    if (w_latch_lvl) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  if (w_latch_fall) w_state_next = ST_SHIFT;
        ST_SHIFT: if (w_clk_rise && r_bits == 4'(NES_BITS - 1)) w_state_next = ST_DONE;
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_shift_next  = r_shift;
    w_bits_next   = r_bits;
    w_data_next   = 1'b1;
    w_strobe_next = (r_state == ST_LOAD) && (w_state_next == ST_SHIFT);
    if (w_state_next == ST_LOAD) begin
      w_shift_next = ~w_buttons_eff;
      w_bits_next  = '0;
    end else if (r_state == ST_SHIFT && w_clk_rise) begin
      w_shift_next = {1'b1, r_shift[NES_BITS-1:1]};
      w_bits_next  = r_bits + 1'b1;
    end
    if (w_state_next == ST_LOAD || w_state_next == ST_SHIFT) begin
      w_data_next = w_shift_next[BTN_A];
    end
  end

  assign o_nes_data     = r_nes_data;
  assign o_busy         = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign o_bits_sent    = r_bits;
  assign o_frame_strobe = r_frame_strobe;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed self-checking bench for nes_controller_responder; expected values are hand-computed.
// Turbo expectations follow whether NES_TURBO_EN is defined for the build.
module tb_nes_controller_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nes_latch = 1'b0;
  logic       nes_clk = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       turbo_a = 1'b0;
  logic       turbo_b = 1'b0;
  logic       nes_data;
  logic       busy;
  logic [3:0] bits_sent;
  logic       frame_strobe;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  nes_controller_responder #(
    .SYNC_STAGES  (2),
    .TURBO_PERIOD (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_nes_latch    (nes_latch),
    .i_nes_clk      (nes_clk),
    .i_buttons      (buttons),
    .i_turbo_a      (turbo_a),
    .i_turbo_b      (turbo_b),
    .o_nes_data     (nes_data),
    .o_busy         (busy),
    .o_bits_sent    (bits_sent),
    .o_frame_strobe (frame_strobe)
  );

  always @(negedge clk) if (frame_strobe) strobe_cnt++;

  task automatic latch_pulse();
    @(negedge clk) nes_latch = 1'b1;
    repeat (4) @(negedge clk);
    nes_latch = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic clock_pulse();
    @(negedge clk) nes_clk = 1'b1;
    repeat (4) @(negedge clk);
    nes_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_frame(input logic [7:0] btn, output logic [7:0] ser);
    buttons = btn;
    latch_pulse();
    for (int i = 0; i < 8; i++) begin
      ser[i] = nes_data;
      clock_pulse();
    end
    $display("frame buttons=%h serial(lsb first)=%h bits_sent=%0d", btn, ser, bits_sent);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nes_latch = i[0];
      nes_clk   = i[1];
      checks++;
      if (nes_data !== 1'b1 || busy !== 1'b0 || bits_sent !== 4'd0 || frame_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: data=%b busy=%b bits=%0d strobe=%b, want 1 0 0 0",
                 i, nes_data, busy, bits_sent, frame_strobe);
      end
    end
    nes_latch = 1'b0;
    nes_clk   = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (nes_data !== 1'b1 || busy !== 1'b0 || bits_sent !== 4'd0 || strobe_cnt !== 0) begin
      errors++;
      $display("FAIL reset_release: data=%b busy=%b bits=%0d strobes=%0d, want 1 0 0 0",
               nes_data, busy, bits_sent, strobe_cnt);
    end
    $display("reset sequence complete");
  endtask

  task automatic test_single_a();
    logic [7:0] ser;
    int         s0;
    s0 = strobe_cnt;
    read_frame(8'h01, ser);
    checks++;
    if (ser !== 8'hFE) begin
      errors++;
      $display("FAIL serial_01: got %h want fe", ser);
    end
    checks++;
    if (bits_sent !== 4'd8 || nes_data !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after8_01: bits=%0d data=%b busy=%b, want 8 1 0", bits_sent, nes_data, busy);
    end
    clock_pulse();
    $display("ninth clock pulse: data=%b bits_sent=%0d busy=%b", nes_data, bits_sent, busy);
    checks++;
    if (bits_sent !== 4'd8 || nes_data !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ninth_pulse: bits=%0d data=%b busy=%b, want 8 1 0", bits_sent, nes_data, busy);
    end
    checks++;
    if (strobe_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL strobe_count: got %0d want 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] ser;
    read_frame(8'h80, ser);
    checks++;
    if (ser !== 8'h7F) begin
      errors++;
      $display("FAIL serial_80: got %h want 7f", ser);
    end
    read_frame(8'h5A, ser);
    checks++;
    if (ser !== 8'hA5) begin
      errors++;
      $display("FAIL serial_5a: got %h want a5", ser);
    end
    checks++;
    if (bits_sent !== 4'd8) begin
      errors++;
      $display("FAIL bits_5a: got %0d want 8", bits_sent);
    end
  endtask

  task automatic test_abort();
    logic [7:0] ser;
    buttons = 8'hFF;
    latch_pulse();
    repeat (3) clock_pulse();
    $display("partial frame: bits_sent=%0d", bits_sent);
    checks++;
    if (bits_sent !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial: bits=%0d busy=%b, want 3 1", bits_sent, busy);
    end
    @(negedge clk) nes_latch = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bits_sent !== 4'd0 || busy !== 1'b1 || nes_data !== 1'b0) begin
      errors++;
      $display("FAIL abort_latch: bits=%0d busy=%b data=%b, want 0 1 0", bits_sent, busy, nes_data);
    end
    nes_latch = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser[i] = nes_data;
      clock_pulse();
    end
    $display("restarted frame serial=%h", ser);
    checks++;
    if (ser !== 8'h00) begin
      errors++;
      $display("FAIL abort_restart: got %h want 00", ser);
    end
  endtask

  task automatic test_no_latch();
    @(negedge clk) reset = 1'b1;
    #1;
    checks++;
    if (nes_data !== 1'b1 || bits_sent !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%b bits=%0d busy=%b, want 1 0 0", nes_data, bits_sent, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    repeat (3) clock_pulse();
    $display("clocks without latch: data=%b bits_sent=%0d", nes_data, bits_sent);
    checks++;
    if (nes_data !== 1'b1 || bits_sent !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_latch: data=%b bits=%0d busy=%b, want 1 0 0", nes_data, bits_sent, busy);
    end
    buttons = 8'h01;
    @(negedge clk);
    nes_latch = 1'b1;
    nes_clk   = 1'b1;
    repeat (4) @(negedge clk);
    nes_clk = 1'b0;
    repeat (4) @(negedge clk);
    nes_latch = 1'b0;
    repeat (5) @(negedge clk);
    $display("coincident latch+clock: data=%b bits_sent=%0d", nes_data, bits_sent);
    checks++;
    if (bits_sent !== 4'd0 || nes_data !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coincident: bits=%0d data=%b busy=%b, want 0 0 1", bits_sent, nes_data, busy);
    end
    clock_pulse();
    checks++;
    if (bits_sent !== 4'd1 || nes_data !== 1'b1) begin
      errors++;
      $display("FAIL first_shift: bits=%0d data=%b, want 1 1", bits_sent, nes_data);
    end
  endtask

  task automatic test_turbo();
    logic [5:0] exp_a;
    logic [5:0] got_a;
    logic [7:0] ser;
`ifdef NES_TURBO_EN
    exp_a = 6'b001100;
`else
    exp_a = 6'b000000;
`endif
    do_reset();
    turbo_a = 1'b1;
    for (int f = 0; f < 6; f++) begin
      read_frame(8'h01, ser);
      got_a[f] = ser[0];
    end
    turbo_a = 1'b0;
    checks++;
    if (got_a !== exp_a) begin
      errors++;
      $display("FAIL turbo_a: got %b want %b (frame0 in lsb)", got_a, exp_a);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_patterns();
    test_abort();
    test_no_latch();
    test_turbo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
